// File: rtl/if_fetch_stage_pkg.sv
// ============================================================================
// Module   : if_fetch_stage_pkg
// Purpose  : Shared fetch-stage types and default parameter values.
// Revision : 1.0
// ============================================================================
`default_nettype none

package if_fetch_stage_pkg;

    localparam int unsigned PC_W_DEF     = 32;
    localparam int unsigned INSTR_W_DEF  = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int unsigned PC_STEP_DEF  = 4;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/if_fetch_stage_pc_reg.sv
// ============================================================================
// Module   : if_fetch_stage_pc_reg
// Purpose  : Program counter with reset value, sequential step and target load.
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_fetch_stage_pc_reg
    import if_fetch_stage_pkg::*;
#(
    parameter int unsigned          PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0]      RESET_PC = PC_W'(RESET_PC_DEF),
    parameter int unsigned          PC_STEP  = PC_STEP_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_inc,
    input  logic            i_load,
    input  logic [PC_W-1:0] i_load_pc,
    output logic [PC_W-1:0] o_pc
);

    logic [PC_W-1:0] r_pc;

    // Load wins over increment; the step wraps modulo 2^PC_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_pc;
        end else if (i_inc) begin
            r_pc <= r_pc + PC_W'(PC_STEP);
        end
    end

    assign o_pc = r_pc;

endmodule

`default_nettype wire

// File: rtl/if_fetch_stage.sv
// ============================================================================
// Module   : if_fetch_stage
// Purpose  : Instruction fetch with single-outstanding imem requests feeding IF/ID.
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int unsigned          PC_W     = PC_W_DEF,
    parameter int unsigned          INSTR_W  = INSTR_W_DEF,
    parameter logic [PC_W-1:0]      RESET_PC = PC_W'(RESET_PC_DEF),
    parameter int unsigned          PC_STEP  = PC_STEP_DEF
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               id_stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               if_valid,
    output logic [PC_W-1:0]    if_pc,
    output logic [INSTR_W-1:0] if_instr
);

    fetch_state_e       r_state;
    fetch_state_e       w_state_nxt;
    logic [PC_W-1:0]    r_tgt;
    logic               r_if_valid;
    logic [PC_W-1:0]    r_if_pc;
    logic [INSTR_W-1:0] r_if_instr;

    logic               w_req;
    logic               w_capture;
    logic               w_pc_inc;
    logic               w_pc_load;
    logic [PC_W-1:0]    w_load_pc;
    logic               w_tgt_load;
    logic               w_valid_nxt;
    logic [PC_W-1:0]    w_pc;

    if_fetch_stage_pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .i_inc     (w_pc_inc),
        .i_load    (w_pc_load),
        .i_load_pc (w_load_pc),
        .o_pc      (w_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // While discarding, the PC keeps the abandoned address on imem_addr and the
    // redirect target waits in r_tgt until the stale response arrives.
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_capture   = 1'b0;
        w_pc_inc    = 1'b0;
        w_pc_load   = 1'b0;
        w_load_pc   = redirect_pc;
        w_tgt_load  = 1'b0;
        w_valid_nxt = r_if_valid & id_stall;
        case (r_state)
            ST_FETCH: begin
                w_req = !(id_stall && r_if_valid);
                if (redirect) begin
                    w_valid_nxt = 1'b0;
                    if (w_req && !imem_ack) begin
                        w_state_nxt = ST_DISCARD;
                        w_tgt_load  = 1'b1;
                    end else begin
                        w_pc_load = 1'b1;
                    end
                end else if (w_req && imem_ack) begin
                    w_capture   = 1'b1;
                    w_pc_inc    = 1'b1;
                    w_valid_nxt = 1'b1;
                end else if (!w_req) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    w_valid_nxt = 1'b0;
                    w_pc_load   = 1'b1;
                    w_state_nxt = ST_FETCH;
                end else if (!id_stall) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_DISCARD: begin
                w_req       = 1'b1;
                w_valid_nxt = 1'b0;
                w_tgt_load  = redirect;
                if (imem_ack) begin
                    w_pc_load   = 1'b1;
                    w_load_pc   = redirect ? redirect_pc : r_tgt;
                    w_state_nxt = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tgt      <= RESET_PC;
            r_if_valid <= 1'b0;
            r_if_pc    <= '0;
            r_if_instr <= '0;
        end else begin
            r_if_valid <= w_valid_nxt;
            if (w_tgt_load) begin
                r_tgt <= redirect_pc;
            end
            if (w_capture) begin
                r_if_pc    <= w_pc;
                r_if_instr <= imem_rdata;
            end
        end
    end

    assign imem_req  = w_req;
    assign imem_addr = w_pc;
    assign if_valid  = r_if_valid;
    assign if_pc     = r_if_pc;
    assign if_instr  = r_if_instr;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
// ============================================================================
// Module   : tb_if_fetch_stage
// Purpose  : Self-checking bench for if_fetch_stage with a reference fetch model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ack, id_stall, redirect, if_valid;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, if_pc, if_instr;

    logic        rst2, req2, valid2;
    logic [31:0] addr2, pc2, instr2, rdata2;

    int errors = 0;
    int checks = 0;
    int lat = 0;
    int mem_cnt = 0;

    // Reference model: the PC seen by the spec, plus flags for "outputs held"
    // and "a stale response still owed", and the address that stale request used.
    logic [31:0] m_pc, m_old, m_ifpc, m_instr;
    bit          m_valid, m_hold, m_drop, m_req;
    logic [31:0] m_addr;
    logic        s_req;
    logic [31:0] s_addr;

    typedef struct {
        bit          stall;
        bit          redir;
        logic [31:0] rpc;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
    } vec_t;
    vec_t vecs[12];

    always #5 clk = ~clk;

    if_fetch_stage #(.PC_W(32), .INSTR_W(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .id_stall(id_stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .if_valid(if_valid),
        .if_pc(if_pc), .if_instr(if_instr)
    );

    if_fetch_stage #(.PC_W(32), .INSTR_W(32), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) u_wrap (
        .clk(clk), .rst(rst2), .imem_req(req2), .imem_addr(addr2),
        .imem_ack(req2), .imem_rdata(rdata2), .id_stall(1'b0),
        .redirect(1'b0), .redirect_pc(32'h0), .if_valid(valid2),
        .if_pc(pc2), .if_instr(instr2)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    assign rdata2 = memf(addr2);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_pc = 32'h0; m_old = 32'h0; m_ifpc = 32'h0; m_instr = 32'h0;
        m_valid = 0; m_hold = 0; m_drop = 0; mem_cnt = 0;
    endtask

    task automatic m_step(input bit stall, input bit redir, input logic [31:0] rpc,
                          input bit req, input bit ack);
        if (m_drop) begin
            if (redir) m_pc = rpc;
            if (ack) m_drop = 0;
            m_valid = 0;
        end else if (redir) begin
            m_valid = 0;
            m_hold  = 0;
            if (req && !ack) begin
                m_drop = 1;
                m_old  = m_pc;
            end
            m_pc = rpc;
        end else if (m_hold) begin
            if (!stall) begin
                m_hold  = 0;
                m_valid = 0;
            end
        end else if (req && ack) begin
            m_valid = 1;
            m_ifpc  = m_pc;
            m_instr = memf(m_pc);
            m_pc    = m_pc + 32'd4;
        end else if (!req) begin
            m_hold = 1;
        end else begin
            m_valid = 0;
        end
    endtask

    // Called at a negedge; returns at the next negedge with outputs settled.
    task automatic cycle(input bit stall, input bit redir, input logic [31:0] rpc);
        bit req_l, ack_l;
        id_stall = stall; redirect = redir; redirect_pc = rpc;
        m_req  = m_drop ? 1'b1 : (m_hold ? 1'b0 : !(stall && m_valid));
        m_addr = m_drop ? m_old : m_pc;
        imem_ack   = m_req && (mem_cnt >= lat);
        imem_rdata = memf(m_addr);
        req_l = m_req; ack_l = imem_ack;
        #1;
        s_req = imem_req; s_addr = imem_addr;
        chk("imem_req", {31'b0, s_req}, {31'b0, m_req});
        if (m_req) chk("imem_addr", s_addr, m_addr);
        @(posedge clk);
        m_step(stall, redir, rpc, req_l, ack_l);
        mem_cnt = (req_l && !ack_l) ? mem_cnt + 1 : 0;
        #1;
        chk("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
        if (m_valid) begin
            chk("if_pc", if_pc, m_ifpc);
            chk("if_instr", if_instr, m_instr);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1;
        id_stall = 0; redirect = 0; redirect_pc = 0; imem_ack = 0; imem_rdata = 0;

        // zero-wait stream, stall while 0x8 presented, redirects with and without stall
        vecs[0]  = '{0, 0, 32'h0,   1, 32'h0,   1, 32'h0};
        vecs[1]  = '{0, 0, 32'h0,   1, 32'h4,   1, 32'h4};
        vecs[2]  = '{0, 0, 32'h0,   1, 32'h8,   1, 32'h8};
        vecs[3]  = '{1, 0, 32'h0,   0, 32'hC,   1, 32'h8};
        vecs[4]  = '{1, 0, 32'h0,   0, 32'hC,   1, 32'h8};
        vecs[5]  = '{1, 0, 32'h0,   0, 32'hC,   1, 32'h8};
        vecs[6]  = '{0, 0, 32'h0,   0, 32'hC,   0, 32'h8};
        vecs[7]  = '{0, 0, 32'h0,   1, 32'hC,   1, 32'hC};
        vecs[8]  = '{0, 1, 32'h100, 1, 32'h10,  0, 32'hC};
        vecs[9]  = '{0, 0, 32'h0,   1, 32'h100, 1, 32'h100};
        vecs[10] = '{1, 1, 32'h200, 0, 32'h104, 0, 32'h100};
        vecs[11] = '{0, 0, 32'h0,   1, 32'h200, 1, 32'h200};

        repeat (2) @(negedge clk);
        chk("rst if_valid", {31'b0, if_valid}, 32'h0);
        chk("rst if_pc", if_pc, 32'h0);
        chk("rst if_instr", if_instr, 32'h0);
        chk("rst imem_req", {31'b0, imem_req}, 32'h1);
        chk("rst imem_addr", imem_addr, 32'h0);
        rst = 1'b0;
        m_reset();

        lat = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].stall, vecs[i].redir, vecs[i].rpc);
            chk($sformatf("vec%0d req", i), {31'b0, s_req}, {31'b0, vecs[i].e_req});
            if (vecs[i].e_req) chk($sformatf("vec%0d addr", i), s_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d valid", i), {31'b0, if_valid}, {31'b0, vecs[i].e_valid});
            chk($sformatf("vec%0d pc", i), if_pc, vecs[i].e_pc);
            if (vecs[i].e_valid)
                chk($sformatf("vec%0d instr", i), if_instr, memf(vecs[i].e_pc));
        end

        // async reset in the middle of a pending fetch
        lat = 2;
        cycle(0, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        chk("async rst if_pc", if_pc, 32'h0);
        chk("async rst imem_addr", imem_addr, 32'h0);
        chk("async rst if_valid", {31'b0, if_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        m_reset();

        // two wait states per request
        lat = 2;
        repeat (3) cycle(0, 0, 0);
        chk("wait first pc", if_pc, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0);
            chk("wait addr held", s_addr, 32'h4);
            if (i < 2) chk("wait valid low", {31'b0, if_valid}, 32'h0);
        end
        chk("wait pc", if_pc, 32'h4);

        // redirect while the fetch of 0x8 is still pending
        cycle(0, 1, 32'h100);
        chk("disc valid", {31'b0, if_valid}, 32'h0);
        cycle(0, 0, 0);
        chk("disc addr hold1", s_addr, 32'h8);
        cycle(0, 0, 0);
        chk("disc addr hold2", s_addr, 32'h8);
        chk("disc dropped", {31'b0, if_valid}, 32'h0);
        cycle(0, 0, 0);
        chk("disc refetch addr", s_addr, 32'h100);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        chk("disc new pc", if_pc, 32'h100);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            lat = $urandom_range(0, 2);
            cycle(($urandom % 3) == 0, ($urandom % 9) == 0,
                  ($urandom % 4 == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC));
        end

        // PC wrap from RESET_PC = 0xFFFF_FFFC
        rst2 = 1'b0;
        #1;
        chk("wrap first addr", addr2, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        chk("wrap valid", {31'b0, valid2}, 32'h1);
        chk("wrap pc0", pc2, 32'hFFFF_FFFC);
        chk("wrap instr0", instr2, memf(32'hFFFF_FFFC));
        @(posedge clk); #1;
        chk("wrap pc1", pc2, 32'h0);
        chk("wrap instr1", instr2, memf(32'h0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
